// File: rtl/wb_slave_mux_pkg.sv
// Shared types and constants for the Wishbone slave multiplexer.
package wb_slave_mux_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned DEC_MSB = 31;
  localparam int unsigned DEC_LSB = 24;

  localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_slave_mux_dec.sv
// Combinational address decoder: upper address byte to one-hot slave select,
// lowest index wins when several bases match.
module wb_slave_mux_dec
  import wb_slave_mux_pkg::*;
#(
  parameter int unsigned                NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*8-1:0]    SLAVE_BASE = {8'h38, 8'h30},
  parameter int unsigned                IDXW       = idx_width(NUM_SLAVES)
) (
  input  logic [DEC_MSB-DEC_LSB:0] adr_byte_i,
  output logic [NUM_SLAVES-1:0]    sel_o,
  output logic [IDXW-1:0]          idx_o,
  output logic                     hit_o
);

  always_comb begin
    sel_o = '0;
    idx_o = '0;
    hit_o = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o && (adr_byte_i == SLAVE_BASE[i*8 +: 8])) begin
        hit_o    = 1'b1;
        idx_o    = IDXW'(i);
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone classic 1-to-N slave multiplexer with registered decode/response.
// Define WB_SLAVE_MUX_TIMEOUT_EN to enable the hung-slave timeout counter.
module wb_slave_mux
  import wb_slave_mux_pkg::*;
#(
  parameter int unsigned             NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_BASE = {8'h38, 8'h30},
  parameter int unsigned             TIMEOUT    = 255,
  parameter logic [WB_DW-1:0]        ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [WB_AW-1:0]            wbs_adr_i,
  input  logic [WB_DW-1:0]            wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [WB_DW-1:0]            wbs_dat_o,
  output logic                        s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_sel_o,
  output logic [WB_AW-1:0]            s_adr_o,
  output logic [WB_DW-1:0]            s_dat_o,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES*WB_DW-1:0] s_dat_i,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned IDXW = idx_width(NUM_SLAVES);

  state_e                  state_q, state_d;
  logic                    s_cyc_q, s_cyc_d;
  logic [NUM_SLAVES-1:0]   s_stb_q, s_stb_d;
  logic                    s_we_q, s_we_d;
  logic [3:0]              s_sel_q, s_sel_d;
  logic [WB_AW-1:0]        s_adr_q, s_adr_d;
  logic [WB_DW-1:0]        s_dat_q, s_dat_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [WB_DW-1:0]        rdat_q, rdat_d;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic [IDXW-1:0]         dec_idx;
  logic                    dec_hit;
  logic                    req;
  logic                    slv_ack;
  logic [WB_DW-1:0]        slv_dat;
  logic                    timeout;

  wb_slave_mux_dec #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .IDXW       (IDXW)
  ) u_dec (
    .adr_byte_i (wbs_adr_i[DEC_MSB:DEC_LSB]),
    .sel_o      (dec_sel),
    .idx_o      (dec_idx),
    .hit_o      (dec_hit)
  );

  assign req     = wbs_cyc_i & wbs_stb_i;
  // Only the latched slave's ack/data matter; other slaves are ignored.
  assign slv_ack = s_ack_i[idx_q];
  assign slv_dat = s_dat_i[WB_DW*idx_q +: WB_DW];

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Fires on the TIMEOUT-th BUSY cycle without an ack.
  assign timeout = (state_q == BUSY) && ((cnt_q + 8'd1) == TIMEOUT_CNT);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    s_cyc_d = s_cyc_q;
    s_stb_d = s_stb_q;
    s_we_d  = s_we_q;
    s_sel_d = s_sel_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          s_we_d  = wbs_we_i;
          s_sel_d = wbs_sel_i;
          s_adr_d = wbs_adr_i;
          s_dat_d = wbs_dat_i;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = BUSY;
            s_cyc_d = 1'b1;
            s_stb_d = dec_sel;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdat_d  = ERR_DATA;
          end
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
          s_stb_d = '0;
        end else if (slv_ack) begin
          state_d = RESP;
          s_cyc_d = 1'b0;
          s_stb_d = '0;
          ack_d   = 1'b1;
          rdat_d  = slv_dat;
        end else if (timeout) begin
          state_d = RESP;
          s_cyc_d = 1'b0;
          s_stb_d = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdat_d  = ERR_DATA;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_cyc_d = 1'b0;
        s_stb_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      s_cyc_q <= 1'b0;
      s_stb_q <= '0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_sel_q <= s_sel_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign err_o     = err_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign s_sel_o   = s_sel_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised Wishbone classic interconnect that splits one management-SoC slave port across NUM_SLAVES user-area slaves, e.g. UART, memory or future peripherals.
- Each slave is selected by the upper address byte.
- Decode and response are registered.
- An unmapped address, or a hung slave, terminates with an error acknowledge instead of stalling the bus.
- Sits in user_project_wrapper between the wbs_* pins and the peripheral instances.

Parameters:
- NUM_SLAVES, 2: number of downstream slaves (1..8).
- SLAVE_BASE, {8'h38,8'h30}: packed NUM_SLAVES*8 bits; byte i is the adr[31:24] match value for slave i.
- TIMEOUT, 255: cycles to wait for a slave ack before forcing an error ack (8-bit counter, 1..255).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an unmapped or timed-out access.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o  out  1  cycle to slaves
- s_stb_o  out  NUM_SLAVES  one-hot strobe per slave
- s_we_o  out  1  registered we
- s_sel_o  out  4  registered sel
- s_adr_o  out  32  registered address
- s_dat_o  out  32  registered write data
- s_ack_i  in  NUM_SLAVES  per-slave ack
- s_dat_i  in  NUM_SLAVES*32  per-slave read data, slave i at bits [32i+31:32i]
- err_o  out  1  one-cycle pulse on error termination
- busy_o  out  1  high while not in IDLE

Behaviour:
- Reset: state IDLE; s_stb_o=0; s_cyc_o=0; wbs_ack_o=0; wbs_dat_o=0; err_o=0; all registered slave-side signals 0; timeout counter 0.
- State IDLE:
  - When wbs_cyc_i&wbs_stb_i, latch adr/dat/we/sel and the decode result.
  - Hit: go to BUSY, assert s_cyc_o and s_stb_o[idx] from the next cycle.
  - Miss: go to RESP with data=ERR_DATA and err flagged.
- Decode: a slave hits when adr[31:24]==SLAVE_BASE byte i. On duplicate bases the lowest index wins.
- State BUSY:
  - Watch only s_ack_i[idx]; acks from other slaves are ignored.
  - On ack: capture the selected s_dat_i slice, drop s_stb_o and s_cyc_o, go to RESP.
  - Counter increments each BUSY cycle.
- State RESP:
  - wbs_ack_o=1 for exactly one cycle, with wbs_dat_o holding the captured data.
  - err_o=1 in the same cycle if the access was an error.
  - Always returns to IDLE.
- wbs_dat_o holds its last value outside RESP.
- Latency: slave ack at cycle k gives master ack at k+1. A minimum hit transaction is 3 cycles (IDLE, BUSY, RESP). A miss is 2 cycles.
- Abort: if wbs_cyc_i falls in BUSY, drop the slave strobe, return to IDLE, emit no ack and no error. A late slave ack arriving in IDLE is ignored.
- Back-to-back: a request present in IDLE directly after RESP is accepted immediately.
- Write data and we are never forwarded to a non-selected slave's strobe.
- A mid-transaction reset clears state immediately and leaves no pending ack.

Optional Feature:
- Macro WB_SLAVE_MUX_TIMEOUT_EN.
- Defined: the counter is present. When the count reaches TIMEOUT in BUSY with no ack, drop the slave strobe and go to RESP with ERR_DATA and err_o pulsed. An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; BUSY waits indefinitely for the ack.

Decomposition:
- Package wb_slave_mux_pkg holds:
  - State enum (IDLE, BUSY, RESP).
  - WB_DW=32, WB_AW=32, DEC_MSB=31, DEC_LSB=24.
  - Default ERR_DATA.
- Sub-module wb_slave_mux_dec: purely combinational; address byte and SLAVE_BASE in, one-hot select, index and hit flag out, with lowest-index priority.

Test Plan:
- Read 0x3800_0004, slave1 acks 2 cycles after its strobe with 0x1234_5678 -> s_stb_o=2'b10; wbs_ack_o one cycle after the slave ack; wbs_dat_o=0x1234_5678; err_o=0.
- Write 0x3000_0010 with data 0xA5 and sel=4'h1 -> s_stb_o=2'b01; s_dat_o=0xA5, s_sel_o=1, s_we_o=1; single master ack; slave 1 never strobed.
- Read 0x4000_0000 (unmapped) -> no slave strobe; ack on the 2nd cycle; wbs_dat_o=0xDEAD_BEEF; err_o pulses once.
- With WB_SLAVE_MUX_TIMEOUT_EN and TIMEOUT=8, slave0 never acks -> strobe drops after 8 BUSY cycles, then ack with 0xDEAD_BEEF and err_o. Without the macro, no ack after 1000 cycles.
- wbs_cyc_i dropped in BUSY, then slave acks late -> no wbs_ack_o; busy_o returns low; the next request completes normally.
- Assert wb_rst_n_i low mid-BUSY -> all outputs 0 asynchronously; after release, the first transaction completes with correct data.
